sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arbiter.sv | 120 ++++++++++++
 tb/tb_sdram_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-beat SDRAM controller.
// One access in flight at a time; each access ends with a done pulse, and err
// is raised with it if the controller never acked.
module sdram_arbiter #(
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic              clock_50m,
    input  logic              reset_n,
    input  logic              m0_req,
    input  logic              m1_req,
    input  logic              m0_we,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_done,
    output logic              m1_done,
    output logic              m0_err,
    output logic              m1_err,
    output logic [DATA_W-1:0] rdata,
    output logic              sdram_wr_req,
    output logic              sdram_rd_req,
    output logic [ADDR_W-1:0] sdram_wr_addr,
    output logic [ADDR_W-1:0] sdram_rd_addr,
    output logic [DATA_W-1:0] sdram_wr_data,
    output logic [8:0]        sdwr_bytes,
    output logic [8:0]        sdrd_bytes,
    input  logic              sdram_wr_ack,
    input  logic              sdram_rd_ack,
    input  logic [DATA_W-1:0] sdram_rd_data,
    input  logic              sdram_init_done,
    input  logic              sdram_busy,
    output logic              grant
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t              state, state_nxt;
    logic [9:0]          wait_cnt;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                err_q;
    logic                accept;
    logic                pick;
    logic                ack_hit;
    logic                timed_out;

    assign accept    = (state == IDLE) && sdram_init_done && !sdram_busy && (m0_req || m1_req);
    assign ack_hit   = we_q ? sdram_wr_ack : sdram_rd_ack;
    assign timed_out = (wait_cnt == 10'(TIMEOUT));

    // Round-robin pick: a lone requester wins, on contention the one not last granted wins
    always_comb begin
        pick = m1_req;
        if (m0_req && m1_req) pick = ~grant;
    end

    // State register
    always_ff @(posedge clock_50m or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state: an ack (even on the timeout cycle) or the timeout is the only way out of WAIT
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = WAIT;
            WAIT:    if (ack_hit || timed_out) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state and the latched access
    always_comb begin
        sdram_wr_req = (state == WAIT) && we_q;
        sdram_rd_req = (state == WAIT) && !we_q;
        m0_done      = (state == DONE) && !grant;
        m1_done      = (state == DONE) && grant;
        m0_err       = m0_done && err_q;
        m1_err       = m1_done && err_q;
    end

    // Latch the winning request, run the wait counter, capture read data and outcome
    always_ff @(posedge clock_50m or negedge reset_n) begin
        if (!reset_n) begin
            grant    <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wait_cnt <= '0;
            err_q    <= 1'b0;
            rdata    <= '0;
        end else begin
            if (accept) begin
                grant    <= pick;
                we_q     <= pick ? m1_we    : m0_we;
                addr_q   <= pick ? m1_addr  : m0_addr;
                wdata_q  <= pick ? m1_wdata : m0_wdata;
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 10'd1;
            end
            if ((state == WAIT) && (ack_hit || timed_out)) err_q <= !ack_hit;
            if ((state == WAIT) && !we_q && sdram_rd_ack) rdata <= sdram_rd_data;
        end
    end

    assign sdram_wr_addr = addr_q;
    assign sdram_rd_addr = addr_q;
    assign sdram_wr_data = wdata_q;
    assign sdwr_bytes    = 9'd1;
    assign sdrd_bytes    = 9'd1;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: expected completions are queued when a
// request is raised and popped when a done pulse appears. A small SDRAM model
// acks after a programmable number of request cycles.
module tb_sdram_arbiter;

    localparam int ADDR_W  = 24;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 1023;

    typedef struct {
        logic        m;
        logic        err;
        logic [15:0] rdata;
    } exp_t;

    logic              clock_50m = 1'b0;
    logic              reset_n   = 1'b0;
    logic              m0_req = 1'b0, m1_req = 1'b0, m0_we = 1'b0, m1_we = 1'b0;
    logic [ADDR_W-1:0] m0_addr = '0, m1_addr = '0;
    logic [DATA_W-1:0] m0_wdata = '0, m1_wdata = '0;
    logic              sdram_wr_ack = 1'b0, sdram_rd_ack = 1'b0;
    logic [DATA_W-1:0] sdram_rd_data = '0;
    logic              sdram_init_done = 1'b1, sdram_busy = 1'b0;
    logic              m0_done, m1_done, m0_err, m1_err, grant;
    logic              sdram_wr_req, sdram_rd_req;
    logic [DATA_W-1:0] rdata, sdram_wr_data;
    logic [ADDR_W-1:0] sdram_wr_addr, sdram_rd_addr;
    logic [8:0]        sdwr_bytes, sdrd_bytes;

    exp_t        sb[$];
    int          n_chk = 0, n_pass = 0, ndone = 0;
    int          seen = 0, ack_at = 0, req_cycles = 0;
    logic        wrong_ack = 1'b0, auto_drop = 1'b1;
    logic [15:0] rd_val = '0, exp_rdata = '0;

    sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clock_50m(clock_50m), .reset_n(reset_n),
        .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_done(m0_done), .m1_done(m1_done), .m0_err(m0_err), .m1_err(m1_err),
        .rdata(rdata), .sdram_wr_req(sdram_wr_req), .sdram_rd_req(sdram_rd_req),
        .sdram_wr_addr(sdram_wr_addr), .sdram_rd_addr(sdram_rd_addr),
        .sdram_wr_data(sdram_wr_data), .sdwr_bytes(sdwr_bytes), .sdrd_bytes(sdrd_bytes),
        .sdram_wr_ack(sdram_wr_ack), .sdram_rd_ack(sdram_rd_ack),
        .sdram_rd_data(sdram_rd_data), .sdram_init_done(sdram_init_done),
        .sdram_busy(sdram_busy), .grant(grant)
    );

    always #5 clock_50m = ~clock_50m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    // One cycle: sample at negedge, score any completion, then drive the SDRAM model
    task automatic step();
        exp_t e;
        @(negedge clock_50m);
        if (sdram_wr_req || sdram_rd_req) chk("req_excl", {31'd0, sdram_wr_req & sdram_rd_req}, 0);
        if (m0_done || m1_done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", {30'd0, m1_done, m0_done}, 0);
            end else begin
                e = sb.pop_front();
                chk("done_onehot", {31'd0, m0_done & m1_done}, 0);
                chk("done_who", {30'd0, m1_done, m0_done}, e.m ? 2 : 1);
                chk("grant", {31'd0, grant}, {31'd0, e.m});
                chk("err", {30'd0, m1_err, m0_err}, e.err ? (e.m ? 2 : 1) : 0);
                chk("rdata", {16'd0, rdata}, {16'd0, e.rdata});
            end
            ndone++;
            if (auto_drop) begin
                if (m0_done) m0_req = 1'b0;
                if (m1_done) m1_req = 1'b0;
            end
        end
        if (sdram_wr_req || sdram_rd_req) begin seen++; req_cycles++; end
        else seen = 0;
        sdram_wr_ack = 1'b0;
        sdram_rd_ack = 1'b0;
        if ((sdram_wr_req || sdram_rd_req) && seen == ack_at) begin
            if (sdram_wr_req) sdram_wr_ack = 1'b1;
            else begin sdram_rd_ack = 1'b1; sdram_rd_data = rd_val; end
        end
        if (wrong_ack && seen == 2) begin
            if (sdram_wr_req) begin sdram_rd_ack = 1'b1; sdram_rd_data = 16'hDEAD; end
            else sdram_wr_ack = 1'b1;
        end
    endtask

    task automatic wait_done(input int target, input int bound);
        int n = 0;
        while (ndone < target && n < bound) begin step(); n++; end
        if (ndone < target) chk("wait_bound", ndone, target);
    endtask

    task automatic wait_req(input int bound);
        int n = 0;
        while (!(sdram_wr_req || sdram_rd_req) && n < bound) begin step(); n++; end
        if (!(sdram_wr_req || sdram_rd_req)) chk("req_bound", {31'd0, sdram_wr_req | sdram_rd_req}, 1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ctl"}, {26'd0, sdram_wr_req, sdram_rd_req, m0_done, m1_done, m0_err, m1_err}, 0);
        chk({tag, "_rdata"}, {16'd0, rdata}, 0);
        chk({tag, "_addr"}, {8'd0, sdram_wr_addr | sdram_rd_addr}, 0);
        chk({tag, "_wdata"}, {16'd0, sdram_wr_data}, 0);
        chk({tag, "_grant"}, {31'd0, grant}, 1);
    endtask

    initial begin
        // Reset state
        #12;
        check_reset("rst");
        chk("bytes", {14'd0, sdwr_bytes, sdrd_bytes}, {14'd0, 9'd1, 9'd1});
        @(negedge clock_50m);
        reset_n = 1'b1;

        // 1: m0 write, ack in 5th request cycle, stray rd_ack ignored
        ack_at = 5; wrong_ack = 1'b1; req_cycles = 0;
        m0_we = 1'b1; m0_addr = 24'h000010; m0_wdata = 16'hA5A5;
        sb.push_back('{m: 1'b0, err: 1'b0, rdata: exp_rdata});
        m0_req = 1'b1;
        wait_done(ndone + 1, 40);
        chk("s1_req_len", req_cycles, 5);
        chk("s1_wdata", {16'd0, sdram_wr_data}, 32'h0000A5A5);
        chk("s1_waddr", {8'd0, sdram_wr_addr}, 32'h00000010);
        req_cycles = 0;
        repeat (3) step();
        chk("s1_no_regrant", req_cycles, 0);

        // 2: m1 read, rdata held after done, stray wr_ack ignored
        ack_at = 3; rd_val = 16'h1234; exp_rdata = 16'h1234;
        m1_we = 1'b0; m1_addr = 24'h000020;
        sb.push_back('{m: 1'b1, err: 1'b0, rdata: exp_rdata});
        m1_req = 1'b1;
        wait_done(ndone + 1, 40);
        chk("s2_raddr", {8'd0, sdram_rd_addr}, 32'h00000020);
        repeat (3) step();
        chk("s2_rdata_held", {16'd0, rdata}, 32'h00001234);
        wrong_ack = 1'b0;

        // 3: reset, then continuous contention -> grants 0,1,0,1
        reset_n = 1'b0; exp_rdata = '0;
        step();
        reset_n = 1'b1;
        ack_at = 2; rd_val = 16'h55AA; auto_drop = 1'b0;
        m0_we = 1'b1; m0_wdata = 16'h0101; m1_we = 1'b0;
        sb.push_back('{m: 1'b0, err: 1'b0, rdata: 16'h0000});
        sb.push_back('{m: 1'b1, err: 1'b0, rdata: 16'h55AA});
        sb.push_back('{m: 1'b0, err: 1'b0, rdata: 16'h55AA});
        sb.push_back('{m: 1'b1, err: 1'b0, rdata: 16'h55AA});
        m0_req = 1'b1; m1_req = 1'b1;
        wait_done(ndone + 4, 80);
        m0_req = 1'b0; m1_req = 1'b0; auto_drop = 1'b1;
        exp_rdata = 16'h55AA;

        // 4: controller not ready holds off the request
        sdram_init_done = 1'b0; req_cycles = 0;
        m0_we = 1'b0; m0_addr = 24'h000030; rd_val = 16'h0F0F;
        m0_req = 1'b1;
        repeat (5) step();
        sdram_init_done = 1'b1; sdram_busy = 1'b1;
        repeat (5) step();
        chk("s4_held_off", req_cycles, 0);
        sdram_busy = 1'b0;
        exp_rdata = 16'h0F0F;
        sb.push_back('{m: 1'b0, err: 1'b0, rdata: exp_rdata});
        step();
        chk("s4_req_next", {31'd0, sdram_rd_req}, 1);
        wait_done(ndone + 1, 40);

        // 5a: read never acked -> timeout, err, rdata unchanged; init_done drop ignored
        ack_at = 0; req_cycles = 0;
        m1_we = 1'b0; m1_addr = 24'h000044;
        sb.push_back('{m: 1'b1, err: 1'b1, rdata: exp_rdata});
        m1_req = 1'b1;
        wait_req(10);
        sdram_init_done = 1'b0;
        wait_done(ndone + 1, TIMEOUT + 50);
        sdram_init_done = 1'b1;
        chk("s5_req_len", req_cycles, TIMEOUT + 1);

        // 5b: ack on the counter==TIMEOUT cycle is a success
        ack_at = TIMEOUT + 1; rd_val = 16'hBEEF; req_cycles = 0;
        exp_rdata = 16'hBEEF;
        m0_we = 1'b0; m0_addr = 24'h000050;
        sb.push_back('{m: 1'b0, err: 1'b0, rdata: exp_rdata});
        m0_req = 1'b1;
        wait_done(ndone + 1, TIMEOUT + 50);
        chk("s5b_req_len", req_cycles, TIMEOUT + 1);

        // 6: reset mid-WAIT clears everything at once, no done, next access is normal
        ack_at = 0;
        m1_we = 1'b1; m1_addr = 24'h000060; m1_wdata = 16'hC3C3;
        m1_req = 1'b1;
        wait_req(10);
        repeat (3) step();
        #2 reset_n = 1'b0;
        #1 check_reset("s6");
        sb.delete();
        m1_req = 1'b0;
        repeat (2) step();
        reset_n = 1'b1; exp_rdata = '0;
        ack_at = 2; rd_val = 16'h7777; exp_rdata = 16'h7777;
        m1_we = 1'b0; m1_addr = 24'h000040;
        sb.push_back('{m: 1'b1, err: 1'b0, rdata: exp_rdata});
        m1_req = 1'b1;
        wait_done(ndone + 1, 40);
        chk("s6_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
